// File: rtl/vm_coin_scheduler_if.sv
// Coin acceptor handshakes, core coin/response wires and sale reporting for vm_coin_scheduler.
// slave is the scheduler side; master is the environment (acceptors, core, host).
interface vm_coin_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             a_valid_i;
    logic [1:0]       a_coin_i;
    logic             a_ready_o;
    logic             b_valid_i;
    logic [1:0]       b_coin_i;
    logic             b_ready_o;
    logic             nickle_o;
    logic             dime_o;
    logic             quarter_o;
    logic             soda_i;
    logic [2:0]       change_i;
    logic             vend_o;
    logic [2:0]       vend_change_o;
    logic [CNT_W-1:0] sale_cnt_o;
    logic             illegal_o;
    logic             busy_o;

    modport slave (
        input  a_valid_i, a_coin_i, b_valid_i, b_coin_i, soda_i, change_i,
        output a_ready_o, b_ready_o, nickle_o, dime_o, quarter_o,
               vend_o, vend_change_o, sale_cnt_o, illegal_o, busy_o
    );

    modport master (
        output a_valid_i, a_coin_i, b_valid_i, b_coin_i, soda_i, change_i,
        input  a_ready_o, b_ready_o, nickle_o, dime_o, quarter_o,
               vend_o, vend_change_o, sale_cnt_o, illegal_o, busy_o
    );
endinterface

// File: rtl/vm_coin_scheduler.sv
// Round-robin merges two coin acceptors into a FIFO and replays each coin as a one-hot pulse
// two cycles after acceptance; readies drop only while the FIFO (registered count) is full.
module vm_coin_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
endmodule

module vm_coin_scheduler #(
    parameter int DEPTH    = 4,
    parameter int RESP_WIN = 3,
    parameter int GAP_CYC  = 1,
    parameter int CNT_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    vm_coin_scheduler_if.slave  bus
);
    localparam int WW = $clog2(RESP_WIN + 2);
    localparam int GW = $clog2(GAP_CYC + 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_coin_q;
    logic [WW-1:0]    r_win_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic             r_rr_b;
    logic             r_vend;
    logic [2:0]       r_vend_change;
    logic [CNT_W-1:0] r_sale_cnt;
    logic             r_illegal;

    logic       w_full;
    logic       w_empty;
    logic       w_a_rdy;
    logic       w_b_rdy;
    logic       w_xfer;
    logic [1:0] w_in_coin;
    logic [1:0] w_head;
    logic       w_push;
    logic       w_pop;
    logic       w_vend;

    // Arbiter: full comes from the registered count, so a same-cycle pop never frees a slot.
    assign w_a_rdy   = !w_full && bus.a_valid_i && (!bus.b_valid_i || !r_rr_b);
    assign w_b_rdy   = !w_full && bus.b_valid_i && (!bus.a_valid_i ||  r_rr_b);
    assign w_xfer    = w_a_rdy || w_b_rdy;
    assign w_in_coin = w_a_rdy ? bus.a_coin_i : bus.b_coin_i;
    assign w_push    = w_xfer && (w_in_coin != 2'b00);

    vm_coin_fifo #(.W(2), .DEPTH(DEPTH)) u_fifo (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_push     (w_push),
        .i_push_dat (w_in_coin),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_vend      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_vend = bus.soda_i;
                if (bus.soda_i || r_win_cnt <= WW'(1))
                    w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_coin_q      <= '0;
            r_win_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_rr_b        <= 1'b0;
            r_vend        <= 1'b0;
            r_vend_change <= '0;
            r_sale_cnt    <= '0;
            r_illegal     <= 1'b0;
        end else begin
            if (w_pop) r_coin_q <= w_head;
            if (r_state == S_ISSUE)     r_win_cnt <= WW'(RESP_WIN);
            else if (r_state == S_WAIT) r_win_cnt <= r_win_cnt - WW'(1);
            // Gap counter is preloaded outside GAP so it is ready on entry.
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - GW'(1);
            else                  r_gap_cnt <= GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
            if (w_a_rdy)      r_rr_b <= 1'b1;
            else if (w_b_rdy) r_rr_b <= 1'b0;
            r_vend <= w_vend;
            if (w_vend) begin
                r_vend_change <= bus.change_i;
                if (r_sale_cnt != '1) r_sale_cnt <= r_sale_cnt + CNT_W'(1);
            end
            r_illegal <= w_xfer && (w_in_coin == 2'b00);
        end
    end

    assign bus.a_ready_o     = w_a_rdy;
    assign bus.b_ready_o     = w_b_rdy;
    assign bus.nickle_o      = (r_state == S_ISSUE) && (r_coin_q == 2'b01);
    assign bus.dime_o        = (r_state == S_ISSUE) && (r_coin_q == 2'b10);
    assign bus.quarter_o     = (r_state == S_ISSUE) && (r_coin_q == 2'b11);
    assign bus.vend_o        = r_vend;
    assign bus.vend_change_o = r_vend_change;
    assign bus.sale_cnt_o    = r_sale_cnt;
    assign bus.illegal_o     = r_illegal;
    assign bus.busy_o        = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_vm_coin_scheduler.sv
// Bench for vm_coin_scheduler: arbitration table, directed multi-cycle sequences and a
// randomized run against an occupancy/timing model of the scheduler.
module tb_vm_coin_scheduler;
    localparam int DEPTH    = 4;
    localparam int RESP_WIN = 3;
    localparam int GAP_CYC  = 1;
    localparam int CNT_W    = 8;
    localparam int NRND     = 3000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    vm_coin_scheduler_if #(.CNT_W(CNT_W)) vif();
    vm_coin_scheduler_if #(.CNT_W(2))     vif2();

    vm_coin_scheduler #(.DEPTH(DEPTH), .RESP_WIN(RESP_WIN), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (vif)
    );

    // Same stimulus into a 2-bit sale counter instance to exercise saturation.
    vm_coin_scheduler #(.DEPTH(DEPTH), .RESP_WIN(RESP_WIN), .GAP_CYC(GAP_CYC), .CNT_W(2)) dut_sat (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (vif2)
    );

    assign vif2.a_valid_i = vif.a_valid_i;
    assign vif2.a_coin_i  = vif.a_coin_i;
    assign vif2.b_valid_i = vif.b_valid_i;
    assign vif2.b_coin_i  = vif.b_coin_i;
    assign vif2.soda_i    = vif.soda_i;
    assign vif2.change_i  = vif.change_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [1:0] issued_q[$];
    always @(negedge clk_i) begin
        check("onehot", int'($countones({vif.nickle_o, vif.dime_o, vif.quarter_o}) <= 1), 1);
        if (vif.nickle_o)  issued_q.push_back(2'd1);
        if (vif.dime_o)    issued_q.push_back(2'd2);
        if (vif.quarter_o) issued_q.push_back(2'd3);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_coins"}, int'({vif.nickle_o, vif.dime_o, vif.quarter_o}), 0);
        check({tag, "_vend"},  int'(vif.vend_o), 0);
        check({tag, "_chg"},   int'(vif.vend_change_o), 0);
        check({tag, "_cnt"},   int'(vif.sale_cnt_o), 0);
        check({tag, "_cnt2"},  int'(vif2.sale_cnt_o), 0);
        check({tag, "_ill"},   int'(vif.illegal_o), 0);
        check({tag, "_busy"},  int'(vif.busy_o), 0);
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        while (vif.busy_o && w < 100) begin
            @(posedge clk_i); #1;
            w++;
        end
        check({tag, "_idle_timeout"}, int'(w < 100), 1);
    endtask

    function automatic logic [1:0] rnd_coin();
        if ($urandom_range(0, 7) == 0) return 2'd0;
        return 2'($urandom_range(1, 3));
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] coin);
        case (coin)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    typedef struct packed {
        logic av;
        logic bv;
        logic ar;
        logic br;
        logic ill;
    } arb_vec_t;

    typedef struct {
        logic [1:0] coin;
        int         acc;
    } ent_t;

    arb_vec_t   tbl[10];
    logic [1:0] clist[6]    = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    bit         rdy_pat[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] drain_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t       mq[$];
        ent_t       tmp;
        int         idx, acc, kf, d, win;
        int         idle_from, vend_at, soda_cyc, m_cnt, m_sales;
        logic [2:0] soda_chg, last_chg, exp_oh;
        bit         found, ill_next, m_ptr_b, full, ear, ebr, exp_pulse, exp_busy;

        vif.a_valid_i = 0; vif.a_coin_i = 0;
        vif.b_valid_i = 0; vif.b_coin_i = 0;
        vif.soda_i    = 0; vif.change_i = 0;

        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 0, 0};
        tbl[2] = '{1, 1, 0, 1, 1};
        tbl[3] = '{1, 1, 1, 0, 1};
        tbl[4] = '{0, 1, 0, 1, 1};
        tbl[5] = '{0, 1, 0, 1, 1};
        tbl[6] = '{1, 1, 1, 0, 1};
        tbl[7] = '{0, 0, 0, 0, 1};
        tbl[8] = '{1, 1, 0, 1, 0};
        tbl[9] = '{0, 0, 0, 0, 1};

        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i); #1;

        // Illegal coins exercise the arbiter without filling the FIFO.
        for (int i = 0; i < 10; i++) begin
            vif.a_valid_i = tbl[i].av; vif.a_coin_i = 2'd0;
            vif.b_valid_i = tbl[i].bv; vif.b_coin_i = 2'd0;
            @(negedge clk_i);
            check($sformatf("arb%0d_a_ready", i), int'(vif.a_ready_o), int'(tbl[i].ar));
            check($sformatf("arb%0d_b_ready", i), int'(vif.b_ready_o), int'(tbl[i].br));
            check($sformatf("arb%0d_illegal", i), int'(vif.illegal_o), int'(tbl[i].ill));
            check($sformatf("arb%0d_busy", i),    int'(vif.busy_o), 0);
            @(posedge clk_i); #1;
        end
        vif.a_valid_i = 0; vif.b_valid_i = 0;
        @(posedge clk_i); #1;

        // Single dime: latency, one-cycle pulse, busy duration.
        vif.a_valid_i = 1; vif.a_coin_i = 2'd2;
        @(negedge clk_i);
        check("dime_a_ready", int'(vif.a_ready_o), 1);
        @(posedge clk_i); #1;
        vif.a_valid_i = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            check($sformatf("dime_k%0d_dime", k), int'(vif.dime_o), int'(k == 1));
            check($sformatf("dime_k%0d_vend", k), int'(vif.vend_o), 0);
            check($sformatf("dime_k%0d_busy", k), int'(vif.busy_o), int'(k <= 5));
            @(posedge clk_i); #1;
        end

        // Fill while the FSM is busy with a nickel: 4 of 6 offers accepted, then drain in order.
        vif.a_valid_i = 1; vif.a_coin_i = 2'd1;
        @(negedge clk_i);
        check("full_seed_ready", int'(vif.a_ready_o), 1);
        @(posedge clk_i); #1;
        vif.a_valid_i = 0;
        issued_q.delete();
        @(posedge clk_i); #1;
        idx = 0; acc = 0;
        for (int j = 0; j < 6; j++) begin
            vif.b_valid_i = 1; vif.b_coin_i = clist[idx];
            @(negedge clk_i);
            check($sformatf("full_b_ready%0d", j), int'(vif.b_ready_o), int'(rdy_pat[j]));
            if (vif.b_ready_o) acc++;
            if (rdy_pat[j]) idx++;
            @(posedge clk_i); #1;
        end
        vif.b_valid_i = 0;
        check("full_accepted", acc, 4);
        wait_idle("full");
        check("drain_len", issued_q.size(), 5);
        for (int j = 0; j < 5; j++)
            check($sformatf("drain_coin%0d", j), (j < issued_q.size()) ? int'(issued_q[j]) : -1,
                  int'(drain_exp[j]));

        // Quarter followed by soda two cycles after its pulse.
        vif.a_valid_i = 1; vif.a_coin_i = 2'd3;
        @(posedge clk_i); #1;
        vif.a_valid_i = 0;
        found = 0; kf = -1;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk_i);
            if (vif.quarter_o) begin
                found = 1; kf = k;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        check("sale_pulse_seen", int'(found), 1);
        check("sale_pulse_latency", kf, 1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        vif.soda_i = 1; vif.change_i = 3'b001;
        @(negedge clk_i);
        check("sale_vend_early", int'(vif.vend_o), 0);
        @(posedge clk_i); #1;
        vif.soda_i = 0; vif.change_i = 3'b110;
        @(negedge clk_i);
        check("sale_vend", int'(vif.vend_o), 1);
        check("sale_change", int'(vif.vend_change_o), 1);
        check("sale_cnt", int'(vif.sale_cnt_o), 1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("sale_vend_once", int'(vif.vend_o), 0);
        check("sale_change_hold", int'(vif.vend_change_o), 1);
        @(posedge clk_i); #1;
        wait_idle("sale");

        // Reset while in WAIT with two coins still queued.
        for (int j = 0; j < 3; j++) begin
            vif.a_valid_i = 1; vif.a_coin_i = 2'(j + 1);
            @(negedge clk_i);
            check($sformatf("rstq_ready%0d", j), int'(vif.a_ready_o), 1);
            @(posedge clk_i); #1;
        end
        vif.a_valid_i = 0; vif.soda_i = 1; vif.change_i = 3'b101; rst_i = 1;
        @(negedge clk_i);
        check("rstq_busy_before", int'(vif.busy_o), 1);
        @(posedge clk_i); #1;
        rst_i = 0; vif.soda_i = 0; vif.change_i = 3'b000;
        issued_q.delete();
        @(negedge clk_i);
        check_all_zero("rstq");
        repeat (8) @(posedge clk_i);
        #1;
        check("rstq_no_issue", issued_q.size(), 0);
        check("rstq_still_idle", int'(vif.busy_o), 0);

        // Randomized run against the occupancy/window model.
        idle_from = 0; vend_at = -10; soda_cyc = -10; m_cnt = 0; m_sales = 0;
        soda_chg = 0; last_chg = 0; ill_next = 0; m_ptr_b = 0;
        for (int c = 0; c < NRND + 100; c++) begin
            vif.a_valid_i = (c < NRND) && ($urandom_range(0, 2) == 0);
            vif.a_coin_i  = rnd_coin();
            vif.b_valid_i = (c < NRND) && ($urandom_range(0, 2) == 0);
            vif.b_coin_i  = rnd_coin();
            vif.soda_i    = (c == soda_cyc);
            vif.change_i  = (c == soda_cyc) ? soda_chg : 3'($urandom_range(0, 7));
            @(negedge clk_i);

            exp_pulse = (c - 1 >= idle_from) && (mq.size() > 0) && (mq.size() > 0 ? mq[0].acc < c - 1 : 1'b0);
            exp_oh = 3'b000;
            if (exp_pulse) begin
                tmp    = mq.pop_front();
                exp_oh = onehot(tmp.coin);
                d      = $urandom_range(1, RESP_WIN + 1);
                soda_cyc = c + d;
                soda_chg = 3'($urandom_range(0, 7));
                if (d <= RESP_WIN) begin
                    vend_at = c + d + 1;
                    win     = d;
                end else begin
                    win = RESP_WIN;
                end
                idle_from = c + win + GAP_CYC + 1;
            end
            check("rnd_coin_out", int'({vif.nickle_o, vif.dime_o, vif.quarter_o}), int'(exp_oh));

            full = (mq.size() == DEPTH);
            ear  = !full && vif.a_valid_i && (!vif.b_valid_i || !m_ptr_b);
            ebr  = !full && vif.b_valid_i && (!vif.a_valid_i || m_ptr_b);
            check("rnd_a_ready", int'(vif.a_ready_o), int'(ear));
            check("rnd_b_ready", int'(vif.b_ready_o), int'(ebr));
            check("rnd_illegal", int'(vif.illegal_o), int'(ill_next));

            if (c == vend_at) begin
                m_sales++;
                last_chg = soda_chg;
                if (m_cnt < 255) m_cnt++;
            end
            check("rnd_vend", int'(vif.vend_o), int'(c == vend_at));
            check("rnd_vend_change", int'(vif.vend_change_o), int'(last_chg));
            check("rnd_sale_cnt", int'(vif.sale_cnt_o), m_cnt);
            check("rnd_sale_cnt_sat", int'(vif2.sale_cnt_o), (m_sales > 3) ? 3 : m_sales);
            exp_busy = (c < idle_from) || (mq.size() > 0);
            check("rnd_busy", int'(vif.busy_o), int'(exp_busy));

            ill_next = 0;
            if (ear) begin
                if (vif.a_coin_i != 2'd0) mq.push_back('{vif.a_coin_i, c});
                else                      ill_next = 1;
                m_ptr_b = 1;
            end else if (ebr) begin
                if (vif.b_coin_i != 2'd0) mq.push_back('{vif.b_coin_i, c});
                else                      ill_next = 1;
                m_ptr_b = 0;
            end
            @(posedge clk_i); #1;
        end
        check("rnd_enough_sales", int'(m_sales >= 5), 1);
        check("rnd_sat_final", int'(vif2.sale_cnt_o), (m_sales > 3) ? 3 : m_sales);
        check("rnd_final_idle", int'(vif.busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vm_coin_scheduler.md
Name: vm_coin_scheduler

Overview:
- Front-end controller for the soda vending machine core. Two coin acceptors (A, B) submit coins through valid/ready handshakes; a round-robin arbiter fills a shared coin FIFO.
- The scheduler replays each queued coin as a single-cycle one-hot pulse on the core's nickle/dime/quarter inputs. It then watches soda/change for a response window and reports each completed sale.
- It guarantees the core never sees two coins in one cycle, and enforces a quiet gap between coins.

Parameters:
- DEPTH, 4, coin FIFO entries (power of two, ≥2)
- RESP_WIN, 3, cycles after the issue pulse during which soda_i is monitored
- GAP_CYC, 1, idle cycles after the window closes before the next coin (0 allowed)
- CNT_W, 8, width of the sale counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- a_valid_i  in  1  acceptor A has a coin
- a_coin_i  in  2  A coin code: 01 nickel, 10 dime, 11 quarter, 00 illegal
- a_ready_o  out  1  A coin accepted this cycle
- b_valid_i  in  1  acceptor B has a coin
- b_coin_i  in  2  B coin code, same encoding as A
- b_ready_o  out  1  B coin accepted this cycle
- nickle_o  out  1  to core nickle_i
- dime_o  out  1  to core dime_i
- quarter_o  out  1  to core quarter_i
- soda_i  in  1  from core soda_o
- change_i  in  3  from core change_o
- vend_o  out  1  one-cycle sale-complete pulse
- vend_change_o  out  3  change captured at the last sale
- sale_cnt_o  out  CNT_W  saturating count of sales
- illegal_o  out  1  one-cycle pulse: an accepted coin had code 00
- busy_o  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset values: all outputs 0; FIFO empty; round-robin pointer = A; FSM = IDLE. Reset asserted in any state (including mid-WAIT) clears everything at that edge. Coin outputs are 0 from the next cycle on.
- Arbitration (combinational ready):
  - full is computed from the registered count. A pop in the same cycle does not free a slot.
  - If full, both readies = 0.
  - Otherwise, if exactly one requester is valid, that requester gets ready = 1.
  - If both are valid, the pointer's requester gets ready = 1.
  - After any grant, the pointer moves to the non-granted requester.
  - At most one enqueue per cycle. A transfer occurs when valid && ready.
- Illegal code 00: handshake completes, coin is not enqueued, illegal_o pulses the next cycle.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into coin_q and go to ISSUE.
  - ISSUE (exactly 1 cycle): drive the one-hot output matching coin_q; all others 0. Load win_cnt = RESP_WIN and go to WAIT.
  - WAIT: coin outputs 0. Sample soda_i each cycle.
    - First cycle with soda_i = 1: register vend_o = 1 and vend_change_o = change_i, increment sale_cnt_o (hold at all-ones), then go to GAP.
    - Otherwise decrement win_cnt. On reaching 0 with no soda, go to GAP with no report.
  - GAP: hold for GAP_CYC cycles, then go to IDLE. If GAP_CYC = 0, WAIT exits directly to IDLE.
- Latency: a coin accepted at edge t (FIFO previously empty, FSM in IDLE) is popped at t+1 and drives its coin output during cycle t+1..t+2 (the ISSUE state).
- vend_o is high exactly one cycle, the cycle after the soda_i sample. vend_change_o holds until the next sale.
- Coin outputs are never more than one-hot, and are never high outside ISSUE.
- Enqueue while the FSM is busy is allowed up to DEPTH entries. FIFO pointers wrap modulo DEPTH.

Test Plan:
- A sends dime (10) at cycle 5, core stub silent → dime_o high for exactly one cycle, two cycles after acceptance; no vend_o; busy_o drops after ISSUE + RESP_WIN + GAP_CYC cycles.
- A and B both valid every cycle with nickel/quarter → readies alternate A, B, A, B starting with A after reset. The core sees nickel, quarter, nickel, quarter, never two coin outputs in one cycle.
- DEPTH = 4, FSM stalled in WAIT, B pushes 6 coins → exactly 4 accepted, b_ready_o = 0 while full. Entries drain in order, including wrap-around.
- Stub drives soda_i = 1 and change_i = 3'b001 two cycles after a quarter pulse → vend_o pulses once, vend_change_o = 001, sale_cnt_o increments 0→1.
- A sends code 00 → a_ready_o = 1, illegal_o pulses next cycle, no coin output, FIFO count unchanged.
- rst_i during WAIT with 2 coins queued → next cycle outputs all 0, FIFO empty, no vend_o. Separately, CNT_W = 2 with 5 sales → sale_cnt_o saturates at 3.
